// File: rtl/pipe_skid_stage_pkg.sv
// Shared defines for the pipeline stage: stage state encodings, stall codes, helpers.
package pipe_skid_stage_pkg;

  // Stage occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Stall reason codes used by the pipeline control.
  localparam logic [1:0] STALL_NONE  = 2'd0;
  localparam logic [1:0] STALL_DOWN  = 2'd1;
  localparam logic [1:0] STALL_FLUSH = 2'd2;

  // Number of valid entries held in a given state.
  function automatic logic [1:0] occ_of(input skid_state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear on clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register stage. SKID=1: two-entry skid buffer with a
// registered in_ready; SKID=0: single entry with combinational in_ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt, skid_q;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Next state and head-of-stage payload; flush overrides any transfer.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire && SKID != 0) begin
          state_nxt = FULL;          // new entry parks in the skid slot
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = RESET_VAL;
    end
  end

  // Head payload register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) main_q <= RESET_VAL;
    else      main_q <= main_nxt;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic skid_ld;
      logic rdy_q;

      assign skid_ld  = (state == ONE) & in_fire & ~out_fire & ~flush;
      assign in_ready = rdy_q;

      // Skid slot: captures the entry that arrives while the head is stalled.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)         skid_q <= RESET_VAL;
        else if (flush)   skid_q <= RESET_VAL;
        else if (skid_ld) skid_q <= in_data;
      end

      // Registered ready: low only while both slots are occupied, so no
      // combinational path from out_ready back to in_ready.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= (state_nxt != FULL);
      end
    end else begin : g_noskid
      assign skid_q   = RESET_VAL;
      assign in_ready = rst & (~out_valid | out_ready);
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

endmodule
